nibble_packer: RTL and testbench

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_packer.sv | 128 ++++++++++++
 tb/tb_nibble_packer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_packer.sv
// nibble_packer: packs variable-count nibble groups into 32-bit words.
// A 16-nibble buffer collects nibbles in arrival order; full 8-nibble words
// are emitted whenever at least 8 nibbles are held, and a flush request
// drains any remaining partial word (upper nibbles zeroed).
// Optional build feature: define NIBBLE_PACKER_STATS_EN to add words_o,
// a wrapping 16-bit count of output handshakes.
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; ready/valid here depend only on registered state.
// state_dbg_o exposes the FSM state (0 = ACCUM, 1 = FLUSH).
module nibble_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] value_i,
    input  logic [3:0]  cnt_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] value_o,
    output logic [3:0]  out_cnt_o,
`ifdef NIBBLE_PACKER_STATS_EN
    output logic [15:0] words_o,
`endif
    output logic        state_dbg_o
);

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [4:0]  fill_q, fill_d;

    logic        in_fire;
    logic        out_fire;
    logic [3:0]  cnt_clamped;
    logic [31:0] in_masked;
    logic [4:0]  pop_n;
    logic [4:0]  base;
    logic [63:0] shifted;

    assign state_dbg_o = state_q;

    // Handshake outputs from registered state; unused nibbles of a partial word read as 0.
    always_comb begin
        out_valid_o = 1'b0;
        out_cnt_o   = 4'd0;
        value_o     = 32'd0;
        in_ready_o  = (state_q == ACCUM) && (fill_q <= 5'd8);
        if (fill_q >= 5'd8) begin
            out_valid_o = 1'b1;
            out_cnt_o   = 4'd8;
        end else if ((state_q == FLUSH) && (fill_q != 5'd0)) begin
            out_valid_o = 1'b1;
            out_cnt_o   = fill_q[3:0];
        end
        for (int i = 0; i < 8; i++) begin
            if (out_valid_o && (4'(i) < out_cnt_o)) begin
                value_o[i*4 +: 4] = buf_q[i*4 +: 4];
            end
        end
    end

    // Buffer update: pop the emitted word first, then append new nibbles behind what remains.
    always_comb begin
        cnt_clamped = (cnt_i > 4'd8) ? 4'd8 : cnt_i;
        in_fire     = in_valid_i && in_ready_o;
        out_fire    = out_valid_o && out_ready_i;
        in_masked   = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < cnt_clamped) begin
                in_masked[i*4 +: 4] = value_i[i*4 +: 4];
            end
        end
        pop_n   = out_fire ? {1'b0, out_cnt_o} : 5'd0;
        base    = fill_q - pop_n;
        shifted = buf_q >> {pop_n, 2'b00};
        buf_d   = shifted;
        fill_d  = base;
        if (in_fire) begin
            // Nibbles at and above fill are always zero, so OR-ing in is safe.
            buf_d  = shifted | ({32'd0, in_masked} << {base, 2'b00});
            fill_d = base + {1'b0, cnt_clamped};
        end
    end

    // Next-state logic: a flush drains everything, then one idle cycle at empty before accepting again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (flush_i) state_d = FLUSH;
            FLUSH:   if (fill_q == 5'd0) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // State, fill level and buffer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ACCUM;
            fill_q  <= 5'd0;
            buf_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
        end
    end

`ifdef NIBBLE_PACKER_STATS_EN
    logic [15:0] words_q;

    // Count of output handshakes, wrapping naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            words_q <= 16'd0;
        end else if (out_fire) begin
            words_q <= words_q + 16'd1;
        end
    end

    assign words_o = words_q;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: a nibble-stream reference model fills an expected
// word queue as nibbles are accepted; a negedge monitor checks every output
// handshake against it, plus ready/valid/state and hold stability.
module tb_nibble_packer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] value_i = 32'd0;
  logic [3:0]  cnt_i = 4'd0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] value_o;
  logic [3:0]  out_cnt_o;
  logic        state_dbg_o;
`ifdef NIBBLE_PACKER_STATS_EN
  logic [15:0] words_o;
`endif

  always #5 clk = ~clk;

  nibble_packer dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .value_i     (value_i),
    .cnt_i       (cnt_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .value_o     (value_o),
    .out_cnt_o   (out_cnt_o),
`ifdef NIBBLE_PACKER_STATS_EN
    .words_o     (words_o),
`endif
    .state_dbg_o (state_dbg_o)
  );

  // ---------------- scoreboard / model ----------------
  int tests = 0;
  int fails = 0;

  logic [35:0] exp_q[$];   // {cnt, word}
  logic [3:0]  nq[$];      // accepted nibbles not yet grouped into a word
  int          m_fill = 0; // nibbles held by the block
  bit          m_flush = 1'b0;
  bit          post_rst = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_val = 32'd0;
  logic [3:0]  prev_cnt = 4'd0;
  int unsigned m_words = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic emit_partial();
    logic [31:0] w;
    int n;
    w = 32'd0;
    n = nq.size();
    for (int j = 0; j < n; j++) w[j*4 +: 4] = nq.pop_front();
    if (n > 0) exp_q.push_back({4'(n), w});
  endtask

  // Monitor: checks outputs at negedge, then applies the coming edge's events to the model.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      nq.delete();
      m_fill    = 0;
      m_flush   = 1'b0;
      m_words   = 0;
      post_rst  = 1'b1;
      prev_hold = 1'b0;
    end else begin
      int c;
      bit nxt_flush;
      logic [35:0] e;
      logic [31:0] w;
      if (post_rst) begin
        check("reset_value", {32'd0, value_o}, 64'd0);
        check("reset_cnt", {60'd0, out_cnt_o}, 64'd0);
        post_rst = 1'b0;
      end
      check("out_valid", {63'd0, out_valid_o}, {63'd0, exp_q.size() != 0});
      check("in_ready", {63'd0, in_ready_o}, {63'd0, (!m_flush && m_fill <= 8)});
      check("state", {63'd0, state_dbg_o}, {63'd0, m_flush});
`ifdef NIBBLE_PACKER_STATS_EN
      check("words", {48'd0, words_o}, {48'd0, m_words[15:0]});
`endif
      if (prev_hold) begin
        check("hold_value", {32'd0, value_o}, {32'd0, prev_val});
        check("hold_cnt", {60'd0, out_cnt_o}, {60'd0, prev_cnt});
      end
      prev_hold = out_valid_o && !out_ready_i;
      prev_val  = value_o;
      prev_cnt  = out_cnt_o;

      nxt_flush = m_flush;
      if (m_flush && m_fill == 0) nxt_flush = 1'b0;

      if (out_valid_o && out_ready_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_word", {28'd0, out_cnt_o, value_o}, {28'd0, e});
        m_fill = m_fill - int'(e[35:32]);
        m_words++;
      end

      if (in_valid_i && in_ready_o) begin
        c = (cnt_i > 4'd8) ? 8 : int'(cnt_i);
        for (int i = 0; i < c; i++) begin
          nq.push_back(value_i[i*4 +: 4]);
          if (nq.size() == 8) begin
            for (int j = 0; j < 8; j++) w[j*4 +: 4] = nq.pop_front();
            exp_q.push_back({4'd8, w});
          end
        end
        m_fill = m_fill + c;
      end

      if (!m_flush && flush_i) begin
        nxt_flush = 1'b1;
        emit_partial();
      end
      m_flush = nxt_flush;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    idle(n);
    rst_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] v, input logic [3:0] c);
    int budget;
    budget = 300;
    in_valid_i = 1'b1;
    value_i    = v;
    cnt_i      = c;
    forever begin
      @(negedge clk);
      if (in_ready_o) break;
      budget--;
      if (budget == 0) begin
        tests++;
        fails++;
        $display("FAIL push_timeout: actual=in_ready_low required=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    value_i    = $urandom;
    cnt_i      = 4'($urandom_range(0, 15));
  endtask

  task automatic flush_pulse();
    flush_i = 1'b1;
    idle(1);
    flush_i = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 500;
    out_ready_i = 1'b1;
    flush_pulse();
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && m_fill == 0 && !m_flush) break;
      budget--;
      if (budget == 0) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: actual=fill_%0d required=empty", m_fill);
        break;
      end
    end
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);

    // Two half words form one full word.
    out_ready_i = 1'b1;
    push(32'h0000_4321, 4'd4);
    push(32'h0000_8765, 4'd4);
    check("fill8_word", {32'd0, value_o}, 64'h8765_4321);
    check("fill8_cnt", {60'd0, out_cnt_o}, 64'd8);
    idle(2);

    // Backpressure at fill 12.
    out_ready_i = 1'b0;
    push(32'h7654_3210, 4'd8);
    push(32'hFFFF_BA98, 4'd4);
    idle(10);
    check("bp_ready_low", {63'd0, in_ready_o}, 64'd0);
    check("bp_value", {32'd0, value_o}, 64'h7654_3210);
    out_ready_i = 1'b1;
    idle(1);
    out_ready_i = 1'b0;
    check("bp_ready_after", {63'd0, in_ready_o}, 64'd1);
    drain();

    // Flush of a 3-nibble partial.
    out_ready_i = 1'b0;
    push(32'h0000_0CBA, 4'd3);
    flush_pulse();
    check("flush_value", {32'd0, value_o}, 64'h0000_0CBA);
    check("flush_cnt", {60'd0, out_cnt_o}, 64'd3);
    out_ready_i = 1'b1;
    idle(3);
    check("flush_return_ready", {63'd0, in_ready_o}, 64'd1);

    // Push and pop in the same cycle at fill 8.
    out_ready_i = 1'b0;
    push(32'h1357_9BDF, 4'd8);
    out_ready_i = 1'b1;
    push(32'hFEDC_BA98, 4'd8);
    check("simul_value", {32'd0, value_o}, 64'hFEDC_BA98);
    check("simul_cnt", {60'd0, out_cnt_o}, 64'd8);
    idle(2);

    // Edge counts with junk upper nibbles.
    push(32'hFFFF_FFFF, 4'd0);
    push(32'hDEAD_BEEF, 4'd15);
    push(32'hFFFF_F123, 4'd3);
    push(32'hFFFF_FF45, 4'd2);
    push(32'hAAAA_A678, 4'd3);
    idle(3);

    // Reset while flushing with a pending word.
    out_ready_i = 1'b0;
    push(32'h0005_4321, 4'd5);
    flush_pulse();
    idle(2);
    do_reset(1);
    check("rst_in_flush", {63'd0, out_valid_o}, 64'd0);
    idle(2);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid_i  = 1'($urandom_range(0, 1));
      value_i     = $urandom;
      cnt_i       = 4'($urandom_range(0, 15));
      flush_i     = ($urandom_range(0, 19) == 0);
      out_ready_i = ($urandom_range(0, 9) < 7);
      rst_i       = ($urandom_range(0, 599) == 0);
      idle(1);
    end
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    rst_i      = 1'b0;
    idle(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
